// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Illegal size is folded in here so the FSM has a single error test at accept time.
  function automatic logic misaligned(input logic [1:0] addr_lo, input mem_size_e size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / data replication, load extract and extend.
// No state, zero latency; the store side and the load side are independent paths.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  mem_size_e   st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_off_i,
  input  mem_size_e   ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sh;
  logic [15:0] half_sh;

  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_H: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      SZ_W:    st_be_o = 4'b1111;
      default: st_be_o = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sh   = 8'(ld_rdata_i >> {ld_off_i, 3'b000});
    half_sh   = 16'(ld_rdata_i >> {ld_off_i[1], 4'b0000});
    ld_data_o = '0;
    case (ld_size_i)
      SZ_B:    ld_data_o = {{24{~ld_unsigned_i & byte_sh[7]}}, byte_sh};
      SZ_H:    ld_data_o = {{16{~ld_unsigned_i & half_sh[15]}}, half_sh};
      SZ_W:    ld_data_o = ld_rdata_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one byte/half/word access per request over a req/ack port, one-cycle response pulse.
// Latency: rsp 1 cycle after an ack (2 after accept minimum), MAX_WAIT cycles for timeout; req_ready low while busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int TW = $clog2(MAX_WAIT + 1);

  lsu_state_e            state_q;
  logic [TW-1:0]         timer_q;
  logic [1:0]            off_q;
  mem_size_e             size_q;
  logic                  unsigned_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_be_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  mem_size_e   size_d;
  logic        bad_d;
  logic        timeout_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data_d;

  assign size_d    = mem_size_e'(req_size);
  assign bad_d     = misaligned(req_addr[1:0], size_d);
  assign timeout_d = (timer_q == TW'(MAX_WAIT - 1));

  lsu_lane_align u_align (
    .st_off_i      (req_addr[1:0]),
    .st_size_i     (size_d),
    .st_wdata_i    (req_wdata),
    .st_be_o       (be_d),
    .st_wdata_o    (wdata_d),
    .ld_off_i      (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (unsigned_q),
    .ld_rdata_i    (mem_rdata),
    .ld_data_o     (ld_data_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      off_q       <= 2'b00;
      size_q      <= SZ_B;
      unsigned_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            off_q       <= req_addr[1:0];
            size_q      <= size_d;
            unsigned_q  <= req_unsigned;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_q <= wdata_d;
            mem_be_q    <= be_d;
            timer_q     <= '0;
            if (bad_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q   <= ACCESS;
              mem_req_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          // An ack on the final wait cycle still completes the access cleanly.
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= mem_we_q ? 32'h0 : ld_data_d;
          end else if (timeout_d) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: stimulus pushes expected responses (data, err, cycle) into a queue; a monitor pops on rsp_valid.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;

  load_store_unit #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [31:0] rdata, input logic err, input int at);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.at    = at;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        check("rsp_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request in IDLE; returns the cycle number of the first cycle after acceptance.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [1:0] size, input logic uns, output int acc);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = wdata;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  // Acks in ACCESS cycle n (0-based), then runs through RESP back to IDLE.
  task automatic ack_in(input int n, input logic [31:0] rd);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step(1);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step(1);
  endtask

  task automatic check_lanes(input string tag, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd, input logic we);
    @(negedge clk);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'h1);
    check({tag, "_be"}, {28'b0, mem_be}, {28'b0, be});
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
    if (we) check({tag, "_wdata"}, mem_wdata, wd);
  endtask

  int a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_mem_be", {28'b0, mem_be}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // SW word, ack in first ACCESS cycle
    issue(32'h100, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, a);
    push(32'h0, 1'b0, a + 1);
    check_lanes("sw", 4'b1111, 32'h100, 32'hDEADBEEF, 1'b1);
    ack_in(0, 32'h0);

    // LB / LBU at byte lane 3
    issue(32'h203, 32'h0, 1'b0, 2'b00, 1'b0, a);
    push(32'hFFFFFF80, 1'b0, a + 1);
    check_lanes("lb", 4'b1000, 32'h200, 32'h0, 1'b0);
    ack_in(0, 32'h80112233);
    issue(32'h203, 32'h0, 1'b0, 2'b00, 1'b1, a);
    push(32'h00000080, 1'b0, a + 1);
    ack_in(0, 32'h80112233);

    // LH upper half, signed
    issue(32'h202, 32'h0, 1'b0, 2'b01, 1'b0, a);
    push(32'hFFFF8011, 1'b0, a + 1);
    check_lanes("lh", 4'b1100, 32'h200, 32'h0, 1'b0);
    ack_in(0, 32'h80112233);

    // SH and SB lane replication
    issue(32'h12, 32'h1234ABCD, 1'b1, 2'b01, 1'b0, a);
    push(32'h0, 1'b0, a + 1);
    check_lanes("sh", 4'b1100, 32'h10, 32'hABCDABCD, 1'b1);
    ack_in(0, 32'h0);
    issue(32'h101, 32'hFFFFFF55, 1'b1, 2'b00, 1'b0, a);
    push(32'h0, 1'b0, a + 1);
    check_lanes("sb", 4'b0010, 32'h100, 32'h55555555, 1'b1);
    ack_in(0, 32'h0);

    // Alignment / illegal size errors: response the cycle after acceptance, no mem_req
    issue(32'h11, 32'h0, 1'b0, 2'b01, 1'b0, a);
    push(32'h0, 1'b1, a);
    @(negedge clk);
    check("lh_mis_mem_req", {31'b0, mem_req}, 32'h0);
    step(1);
    issue(32'h102, 32'h0, 1'b0, 2'b10, 1'b0, a);
    push(32'h0, 1'b1, a);
    step(1);
    issue(32'h100, 32'h0, 1'b0, 2'b11, 1'b0, a);
    push(32'h0, 1'b1, a);
    @(negedge clk);
    check("bad_size_mem_req", {31'b0, mem_req}, 32'h0);
    step(1);

    // Timeout, then a late ack that must be ignored
    issue(32'h40, 32'h0, 1'b0, 2'b10, 1'b0, a);
    push(32'h0, 1'b1, a + MW);
    step(MW - 1);
    @(negedge clk);
    check("to_last_mem_req", {31'b0, mem_req}, 32'h1);
    step(1);
    @(negedge clk);
    check("to_resp_mem_req", {31'b0, mem_req}, 32'h0);
    step(2);
    mem_ack   = 1'b1;
    mem_rdata = 32'h11111111;
    step(1);
    mem_ack   = 1'b0;
    @(negedge clk);
    check("late_ack_ready", {31'b0, req_ready}, 32'h1);
    check("late_ack_mem_req", {31'b0, mem_req}, 32'h0);
    step(1);

    // Ack on the timeout cycle wins
    issue(32'h44, 32'h0, 1'b0, 2'b10, 1'b0, a);
    push(32'hCAFEF00D, 1'b0, a + MW);
    ack_in(MW - 1, 32'hCAFEF00D);

    // Back-to-back requests with req_valid held high
    req_valid = 1'b1; req_addr = 32'h22; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b1;
    step(1);
    a = cyc;
    req_unsigned = 1'b0;
    push(32'h00008001, 1'b0, a + 1);
    push(32'hFFFF8001, 1'b0, a + 4);
    mem_ack = 1'b1; mem_rdata = 32'h80017FFF;
    @(negedge clk);
    check("b2b_ready_access", {31'b0, req_ready}, 32'h0);
    step(1);
    mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_ready_resp", {31'b0, req_ready}, 32'h0);
    step(1);
    @(negedge clk);
    check("b2b_ready_idle", {31'b0, req_ready}, 32'h1);
    step(1);
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h80017FFF;
    @(negedge clk);
    check("b2b_second_mem_req", {31'b0, mem_req}, 32'h1);
    step(1);
    mem_ack = 1'b0;
    step(1);

    // Reset in the middle of an access
    issue(32'h80, 32'h0, 1'b0, 2'b10, 1'b0, a);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    step(2);
    rst_n = 1'b1;
    step(1);
    issue(32'h84, 32'h0, 1'b0, 2'b10, 1'b0, a);
    push(32'h12345678, 1'b0, a + 1);
    check_lanes("post_rst_lw", 4'b1111, 32'h84, 32'h0, 1'b0);
    ack_in(0, 32'h12345678);
    step(2);

    check("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
